// File: rtl/mem_arbiter.sv
// Arbitrates the single-port synchronous memory between instruction fetch and
// load/store data, with data priority, a fetch anti-starvation counter and fetch flush.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [31:0]       d_req_wdata,
    input  logic [3:0]        d_req_wstrb,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        dbg_starve_cnt,
    output logic [1:0]        dbg_rsp_owner
);

    // Handshake: a request transfers in the cycle where valid && ready; the requester
    // holds addr/we/wdata/wstrb stable until then. Ready is a combinational function of
    // the valids, if_flush, the starvation count and rst only -- never of mem_rdata.
    // Responses arrive exactly one cycle after the transfer and cannot be stalled.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    owner_t     rsp_owner, rsp_owner_next;
    logic [3:0] starve_cnt, starve_cnt_next;
    logic       fetch_ok;
    logic       grant_if;
    logic       grant_d;
    logic       unused_addr_lsbs;

    assign unused_addr_lsbs = ^{if_req_addr[1:0], d_req_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_owner  <= OWN_NONE;
            starve_cnt <= 4'd0;
        end else begin
            rsp_owner  <= rsp_owner_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    always_comb begin
        fetch_ok        = if_req_valid && !if_flush;
        grant_if        = 1'b0;
        grant_d         = 1'b0;
        rsp_owner_next  = OWN_NONE;
        starve_cnt_next = starve_cnt;

        if (!rst) begin
            if (fetch_ok && starve_cnt == STARVE_LIM) begin
                grant_if = 1'b1;
            end else if (d_req_valid) begin
                grant_d = 1'b1;
            end else if (fetch_ok) begin
                grant_if = 1'b1;
            end
        end

        if (grant_d) begin
            rsp_owner_next = OWN_D;
        end else if (grant_if) begin
            rsp_owner_next = OWN_IF;
        end

        // A flushed fetch is neither denied nor served, so the streak is frozen.
        if (!if_req_valid || grant_if) begin
            starve_cnt_next = 4'd0;
        end else if (fetch_ok && starve_cnt != STARVE_LIM) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end
    end

    always_comb begin
        mem_en    = grant_if || grant_d;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = d_req_wdata;
        if (grant_d) begin
            mem_addr = d_req_addr[ADDR_W-1:2];
            if (d_req_we) begin
                mem_we = d_req_wstrb;
            end
        end else if (grant_if) begin
            mem_addr = if_req_addr[ADDR_W-1:2];
        end
    end

    // Responses are masked during reset so an in-flight read never leaks out.
    assign if_req_ready   = grant_if;
    assign d_req_ready    = grant_d;
    assign if_rsp_valid   = !rst && (rsp_owner == OWN_IF) && !if_flush;
    assign d_rsp_valid    = !rst && (rsp_owner == OWN_D);
    assign if_rsp_rdata   = mem_rdata;
    assign d_rsp_rdata    = mem_rdata;
    assign dbg_starve_cnt = starve_cnt;
    assign dbg_rsp_owner  = rsp_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference (grant rule, denial streak, word memory, response queue).
module tb_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req_valid, if_req_ready, if_flush, if_rsp_valid;
    logic [ADDR_W-1:0] if_req_addr;
    logic [31:0]       if_rsp_rdata;
    logic              d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic [31:0]       d_req_wdata, d_rsp_rdata;
    logic [3:0]        d_req_wstrb;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata, mem_rdata;
    logic [3:0]        dbg_starve_cnt;
    logic [1:0]        dbg_rsp_owner;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_starve_cnt(dbg_starve_cnt), .dbg_rsp_owner(dbg_rsp_owner)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment memory (256 words, 1-cycle read) ----------------
    function automatic logic [31:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 4) return 32'h0000_0013;
        return {b, ~b, b ^ 8'h5A, 8'hC3};
    endfunction

    logic [31:0] mem [256];
    logic        preload_done = 1'b0;

    always @(posedge clk) begin
        if (!preload_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[7:0]];
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[7:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [256];
    logic [31:0] exp_q[$];        // read data expected in the next response cycle
    int          ref_cnt;         // consecutive cycles fetch asked and was refused
    int          ref_owner;       // 0 none, 1 fetch, 2 data
    bit          ref_rsp_store;
    int          exp_grant;       // 0 none, 1 fetch, 2 data
    bit          exp_if_rsp, exp_d_rsp;
    logic [31:0] exp_rdata;
    logic [29:0] exp_mem_addr;
    logic [3:0]  exp_mem_we;

    function automatic void model_eval();
        bit fetch_wants;
        fetch_wants = if_req_valid && !if_flush;
        if (rst)                                         exp_grant = 0;
        else if (fetch_wants && ref_cnt == STARVE_MAX)   exp_grant = 1;
        else if (d_req_valid)                            exp_grant = 2;
        else if (fetch_wants)                            exp_grant = 1;
        else                                             exp_grant = 0;
        exp_if_rsp   = !rst && ref_owner == 1 && !if_flush;
        exp_d_rsp    = !rst && ref_owner == 2;
        exp_rdata    = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
        exp_mem_addr = (exp_grant == 2) ? d_req_addr[31:2] : if_req_addr[31:2];
        exp_mem_we   = (exp_grant == 2 && d_req_we) ? d_req_wstrb : 4'b0000;
    endfunction

    function automatic void model_advance();
        int w;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (rst) begin
            ref_cnt = 0; ref_owner = 0; exp_q.delete();
            return;
        end
        ref_owner = exp_grant;
        if (exp_grant == 2) begin
            w = int'(d_req_addr[9:2]);
            ref_rsp_store = d_req_we;
            if (d_req_we) begin
                exp_q.push_back(32'h0);
                for (int b = 0; b < 4; b++)
                    if (d_req_wstrb[b]) ref_mem[w][b*8 +: 8] = d_req_wdata[b*8 +: 8];
            end else begin
                exp_q.push_back(ref_mem[w]);
            end
        end else if (exp_grant == 1) begin
            exp_q.push_back(ref_mem[int'(if_req_addr[9:2])]);
        end
        if (!if_req_valid || exp_grant == 1) ref_cnt = 0;
        else if (!if_flush && ref_cnt < STARVE_MAX) ref_cnt = ref_cnt + 1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input logic [31:0] ia, input bit fl,
                         input bit dv, input logic [31:0] da, input bit we,
                         input logic [31:0] wd, input logic [3:0] ws);
        if_req_valid = iv; if_req_addr = ia; if_flush = fl;
        d_req_valid = dv; d_req_addr = da; d_req_we = we; d_req_wdata = wd; d_req_wstrb = ws;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1, 32'h10, 0, 1, 32'h20, 0, 32'h0, 4'h0);
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if ({if_req_ready, d_req_ready, mem_en, if_rsp_valid, d_rsp_valid} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d got rdy/rdy/en/rsp/rsp=%b required 00000", c,
                         {if_req_ready, d_req_ready, mem_en, if_rsp_valid, d_rsp_valid});
            end
            tick();
        end
        rst = 1'b0;
        settle();
        checks++;
        if (dbg_starve_cnt !== 4'd0 || dbg_rsp_owner !== 2'd0) begin
            failures++;
            $display("FAIL reset_state got cnt=%0d owner=%0d required 0 0", dbg_starve_cnt, dbg_rsp_owner);
        end
        checks++;
        if (d_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_first_grant got d_ready=%b if_ready=%b required 1 0", d_req_ready, if_req_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
    endtask

    task automatic test_single_fetch();
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (if_req_ready !== 1'b1 || mem_addr !== 30'd4 || mem_we !== 4'b0 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL fetch_issue got ready=%b en=%b addr=%0d we=%b required 1 1 4 0000",
                     if_req_ready, mem_en, mem_addr, mem_we);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (if_rsp_valid !== 1'b1 || if_rsp_rdata !== 32'h0000_0013 || d_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_rsp got valid=%b rdata=%h d_valid=%b required 1 00000013 0",
                     if_rsp_valid, if_rsp_rdata, d_rsp_valid);
        end
        tick();
    endtask

    task automatic test_store_load();
        drive(0, 0, 0, 1, 32'h20, 1, 32'hDEAD_BEEF, 4'b0011);
        settle();
        checks++;
        if (d_req_ready !== 1'b1 || mem_we !== 4'b0011 || mem_addr !== 30'd8 || mem_wdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL store_issue got ready=%b we=%b addr=%0d wdata=%h required 1 0011 8 deadbeef",
                     d_req_ready, mem_we, mem_addr, mem_wdata);
        end
        tick();
        drive(0, 0, 0, 1, 32'h20, 0, 32'h0, 4'h0);
        settle();
        checks++;
        if (d_rsp_valid !== 1'b1 || d_req_ready !== 1'b1 || mem_we !== 4'b0) begin
            failures++;
            $display("FAIL store_ack got d_rsp=%b ready=%b we=%b required 1 1 0000", d_rsp_valid, d_req_ready, mem_we);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_rdata[15:0] !== 16'hBEEF || d_rsp_rdata !== exp_rdata) begin
            failures++;
            $display("FAIL load_rsp got valid=%b rdata=%h required 1 %h", d_rsp_valid, d_rsp_rdata, exp_rdata);
        end
        tick();
    endtask

    task automatic test_starvation();
        int pat [8] = '{2, 2, 2, 1, 2, 2, 2, 1};
        int cnt [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(1, 32'h100 + 32'(c * 4), 0, 1, 32'h200 + 32'(c * 4), 0, 0, 0);
            settle();
            checks++;
            if ({if_req_ready, d_req_ready} !== {pat[c] == 1, pat[c] == 2} || dbg_starve_cnt !== 4'(cnt[c])) begin
                failures++;
                $display("FAIL starve_pattern cycle=%0d got if=%b d=%b cnt=%0d required grant=%0d cnt=%0d",
                         c, if_req_ready, d_req_ready, dbg_starve_cnt, pat[c], cnt[c]);
            end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (dbg_starve_cnt !== 4'd0) begin
            failures++;
            $display("FAIL starve_clear got cnt=%0d required 0", dbg_starve_cnt);
        end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 32'h40, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (if_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_setup got if_ready=%b required 1", if_req_ready);
        end
        tick();
        drive(1, 32'h44, 1, 1, 32'h20, 0, 0, 0);
        settle();
        checks++;
        if (if_rsp_valid !== 1'b0 || if_req_ready !== 1'b0 || d_req_ready !== 1'b1 || dbg_starve_cnt !== 4'(ref_cnt)) begin
            failures++;
            $display("FAIL flush_cycle got if_rsp=%b if_ready=%b d_ready=%b cnt=%0d required 0 0 1 %0d",
                     if_rsp_valid, if_req_ready, d_req_ready, dbg_starve_cnt, ref_cnt);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (d_rsp_valid !== 1'b1 || d_rsp_rdata !== exp_rdata || if_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_data_rsp got valid=%b rdata=%h if_rsp=%b required 1 %h 0",
                     d_rsp_valid, d_rsp_rdata, if_rsp_valid, exp_rdata);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        drive(1, 32'h10, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        rst = 1'b1;
        drive(1, 32'h14, 0, 1, 32'h24, 0, 0, 0);
        settle();
        checks++;
        if (if_rsp_valid !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_cycle got if_rsp=%b mem_en=%b required 0 0", if_rsp_valid, mem_en);
        end
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        checks++;
        if (if_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0 || dbg_starve_cnt !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid_after got if_rsp=%b d_rsp=%b cnt=%0d required 0 0 0",
                     if_rsp_valid, d_rsp_valid, dbg_starve_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        bit          if_pend = 0, d_pend = 0;
        logic [31:0] ia = 0, da = 0, wd = 0;
        bit          we = 0;
        logic [3:0]  ws = 0;
        for (int c = 0; c < 600; c++) begin
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1; ia = 32'($urandom_range(0, 1023));
            end
            if (!d_pend && $urandom_range(0, 2) != 0) begin
                d_pend = 1; da = 32'($urandom_range(0, 1023)); we = 1'($urandom_range(0, 1));
                wd = $urandom; ws = 4'($urandom_range(0, 15));
            end
            rst = ($urandom_range(0, 79) == 0);
            drive(if_pend, ia, $urandom_range(0, 7) == 0, d_pend, da, we, wd, ws);
            settle();
            checks++;
            if ({if_req_ready, d_req_ready, mem_en} !== {exp_grant == 1, exp_grant == 2, exp_grant != 0}) begin
                failures++;
                $display("FAIL rand_grant cycle=%0d got if/d/en=%b%b%b required grant=%0d",
                         c, if_req_ready, d_req_ready, mem_en, exp_grant);
            end
            if (exp_grant != 0) begin
                checks++;
                if (mem_addr !== exp_mem_addr || mem_we !== exp_mem_we || (exp_mem_we != 0 && mem_wdata !== wd)) begin
                    failures++;
                    $display("FAIL rand_mem cycle=%0d got addr=%h we=%b wdata=%h required %h %b %h",
                             c, mem_addr, mem_we, mem_wdata, exp_mem_addr, exp_mem_we, wd);
                end
            end
            checks++;
            if ({if_rsp_valid, d_rsp_valid} !== {exp_if_rsp, exp_d_rsp}) begin
                failures++;
                $display("FAIL rand_rsp_valid cycle=%0d got if=%b d=%b required %b %b",
                         c, if_rsp_valid, d_rsp_valid, exp_if_rsp, exp_d_rsp);
            end
            if (exp_if_rsp || (exp_d_rsp && !ref_rsp_store)) begin
                checks++;
                if ((exp_if_rsp ? if_rsp_rdata : d_rsp_rdata) !== exp_rdata) begin
                    failures++;
                    $display("FAIL rand_rdata cycle=%0d got if=%h d=%h required %h",
                             c, if_rsp_rdata, d_rsp_rdata, exp_rdata);
                end
            end
            checks++;
            if (dbg_starve_cnt !== 4'(ref_cnt)) begin
                failures++;
                $display("FAIL rand_starve cycle=%0d got %0d required %0d", c, dbg_starve_cnt, ref_cnt);
            end
            if (exp_grant == 1) if_pend = 0;
            if (exp_grant == 2) d_pend = 0;
            tick();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        ref_cnt = 0; ref_owner = 0; ref_rsp_store = 0;
        repeat (2) @(posedge clk);
        #1;
        preload_done = 1'b1;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_starvation();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
